// File: rtl/pool_seq_v2.sv
// Pooling sequencer: streams one feature-map plane per lane per channel block, drives the PE
// shift strobes and issues window write-backs after the PE pooling latency.
module pool_seq_v2 #(
  parameter int N_PE     = 4,
  parameter int DIM_W    = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WIN  = 4,
  parameter int LAT_POOL = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DIM_W-1:0]  i_cfg_wid,
  input  logic [DIM_W-1:0]  i_cfg_hei,
  input  logic [DIM_W-1:0]  i_cfg_ch,
  input  logic [2:0]        i_cfg_ph,
  input  logic [2:0]        i_cfg_pv,
  input  logic [2:0]        i_cfg_sh,
  input  logic [2:0]        i_cfg_sv,
  input  logic              i_cfg_avg,
  output logic [N_PE-1:0]   o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [N_PE-1:0]   o_shift_en,
  output logic              o_lb_reset,
  output logic              o_pool_avg,
  output logic [3:0]        o_avg_shift,
  output logic [N_PE-1:0]   o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_buf_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cfg_err,
  output logic [2:0]        o_state
);

  localparam int LG_N = $clog2(N_PE);
  localparam int DRN_W = (LAT_POOL > 1) ? $clog2(LAT_POOL) : 1;
  localparam logic [2:0] MW = 3'(MAX_WIN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHK      = 3'd1,
    S_BLK_INIT = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  state_t              r_state;
  logic [DIM_W-1:0]    r_wid, r_hei, r_ch;
  logic [2:0]          r_ph, r_pv, r_sh, r_sv;
  logic                r_avg;
  logic [DIM_W-1:0]    r_blk, r_nblk;
  logic [DIM_W-1:0]    r_rc, r_rr;
  logic [DIM_W-1:0]    r_sc, r_sr;
  logic [2:0]          r_hph, r_vph;
  logic [N_PE-1:0]     r_mask, r_rd_en, r_shift_en;
  logic [ADDR_W-1:0]   r_rd_ptr, r_wr_ptr;
  logic [LAT_POOL-1:0] r_vsr;
  logic [DRN_W-1:0]    r_drain;
  logic                r_lb_reset, r_pool_avg, r_buf_sel, r_busy, r_done, r_cfg_err;
  logic [3:0]          r_avg_shift;

  logic [5:0]       w_prod;
  logic             w_pow2;
  logic [3:0]       w_log2;
  logic             w_err;
  logic [DIM_W:0]   w_ch_up;
  logic [DIM_W-1:0] w_nblk;
  logic [LG_N-1:0]  w_rem;
  logic             w_last_blk;
  logic [N_PE-1:0]  w_mask_blk;
  logic [DIM_W-1:0] w_wid_m1, w_hei_m1, w_ph_m1, w_pv_m1;
  logic             w_rd_last, w_sh_act, w_sh_last, w_win_valid;
  logic [2:0]       w_hph_inc, w_vph_inc;

  assign w_prod = {3'b000, r_ph} * {3'b000, r_pv};
  assign w_pow2 = ((w_prod & (w_prod - 6'd1)) == 6'd0);

  // Highest set bit of the window area; exact log2 once area is known to be a power of 2.
  always_comb begin
    w_log2 = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (w_prod[i]) w_log2 = 4'(i);
    end
  end

  assign w_err = (r_ph == 3'd0) || (r_pv == 3'd0) || (r_sh == 3'd0) || (r_sv == 3'd0) ||
                 (r_ph > MW) || (r_pv > MW) ||
                 (DIM_W'(r_ph) > r_wid) || (DIM_W'(r_pv) > r_hei) ||
                 (r_ch == '0) || (r_avg && !w_pow2);

  // Block count and last-block lane mask come straight from the low bits of C.
  assign w_ch_up    = {1'b0, r_ch} + (DIM_W+1)'(N_PE - 1);
  assign w_nblk     = DIM_W'(w_ch_up >> LG_N);
  assign w_rem      = r_ch[LG_N-1:0];
  assign w_last_blk = (r_blk == r_nblk - DIM_W'(1));
  assign w_mask_blk = (w_last_blk && (w_rem != '0)) ? ((N_PE'(1) << w_rem) - N_PE'(1)) : '1;

  assign w_wid_m1 = r_wid - DIM_W'(1);
  assign w_hei_m1 = r_hei - DIM_W'(1);
  assign w_ph_m1  = DIM_W'(r_ph) - DIM_W'(1);
  assign w_pv_m1  = DIM_W'(r_pv) - DIM_W'(1);

  assign w_rd_last   = (r_rc == w_wid_m1) && (r_rr == w_hei_m1);
  assign w_sh_act    = |r_shift_en;
  assign w_sh_last   = w_sh_act && (r_sc == w_wid_m1) && (r_sr == w_hei_m1);
  assign w_win_valid = w_sh_act && (r_sc >= w_ph_m1) && (r_sr >= w_pv_m1) &&
                       (r_hph == 3'd0) && (r_vph == 3'd0);
  assign w_hph_inc   = (r_hph == r_sh - 3'd1) ? 3'd0 : r_hph + 3'd1;
  assign w_vph_inc   = (r_vph == r_sv - 3'd1) ? 3'd0 : r_vph + 3'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_wid       <= '0;
      r_hei       <= '0;
      r_ch        <= '0;
      r_ph        <= '0;
      r_pv        <= '0;
      r_sh        <= '0;
      r_sv        <= '0;
      r_avg       <= 1'b0;
      r_blk       <= '0;
      r_nblk      <= '0;
      r_rc        <= '0;
      r_rr        <= '0;
      r_sc        <= '0;
      r_sr        <= '0;
      r_hph       <= '0;
      r_vph       <= '0;
      r_mask      <= '0;
      r_rd_en     <= '0;
      r_shift_en  <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_vsr       <= '0;
      r_drain     <= '0;
      r_lb_reset  <= 1'b1;
      r_pool_avg  <= 1'b0;
      r_avg_shift <= '0;
      r_buf_sel   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      // The delay line models the PE pooling latency; its tail is the write strobe.
      r_vsr <= (r_vsr << 1) | LAT_POOL'(w_win_valid);
      if (r_vsr[LAT_POOL-1]) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);

      if (i_abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_rd_en    <= '0;
        r_shift_en <= '0;
        r_vsr      <= '0;
        r_busy     <= 1'b0;
        r_lb_reset <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_wid   <= i_cfg_wid;
              r_hei   <= i_cfg_hei;
              r_ch    <= i_cfg_ch;
              r_ph    <= i_cfg_ph;
              r_pv    <= i_cfg_pv;
              r_sh    <= i_cfg_sh;
              r_sv    <= i_cfg_sv;
              r_avg   <= i_cfg_avg;
              r_busy  <= 1'b1;
              r_state <= S_CHK;
            end
          end
          S_CHK: begin
            if (w_err) begin
              r_cfg_err <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_blk       <= '0;
              r_nblk      <= w_nblk;
              r_rd_ptr    <= '0;
              r_wr_ptr    <= '0;
              r_pool_avg  <= r_avg;
              r_avg_shift <= r_avg ? w_log2 : 4'd0;
              r_lb_reset  <= 1'b1;
              r_state     <= S_BLK_INIT;
            end
          end
          S_BLK_INIT: begin
            r_mask     <= w_mask_blk;
            r_rd_en    <= w_mask_blk;
            r_shift_en <= '0;
            r_rc       <= '0;
            r_rr       <= '0;
            r_sc       <= '0;
            r_sr       <= '0;
            r_hph      <= '0;
            r_vph      <= '0;
            r_lb_reset <= 1'b0;
            r_state    <= S_STREAM;
          end
          S_STREAM: begin
            r_shift_en <= r_rd_en;
            if (|r_rd_en) begin
              r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
              if (r_rc == w_wid_m1) begin
                r_rc <= '0;
                r_rr <= r_rr + DIM_W'(1);
              end else begin
                r_rc <= r_rc + DIM_W'(1);
              end
              if (w_rd_last) r_rd_en <= '0;
            end
            // Phases sit at 0 until the first full window, then count modulo the stride.
            if (w_sh_act) begin
              if (r_sc == w_wid_m1) begin
                r_sc  <= '0;
                r_hph <= 3'd0;
                r_sr  <= r_sr + DIM_W'(1);
                r_vph <= (r_sr < w_pv_m1) ? 3'd0 : w_vph_inc;
              end else begin
                r_sc  <= r_sc + DIM_W'(1);
                r_hph <= (r_sc < w_ph_m1) ? 3'd0 : w_hph_inc;
              end
              if (w_sh_last) begin
                r_drain <= DRN_W'(LAT_POOL - 1);
                r_state <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            r_shift_en <= '0;
            if (r_drain == '0) begin
              r_lb_reset <= 1'b1;
              if (w_last_blk) begin
                r_done    <= 1'b1;
                r_buf_sel <= ~r_buf_sel;
                r_state   <= S_FIN;
              end else begin
                r_blk   <= r_blk + DIM_W'(1);
                r_state <= S_BLK_INIT;
              end
            end else begin
              r_drain <= r_drain - DRN_W'(1);
            end
          end
          S_FIN: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_ptr;
  assign o_shift_en  = r_shift_en;
  assign o_lb_reset  = r_lb_reset;
  assign o_pool_avg  = r_pool_avg;
  assign o_avg_shift = r_avg_shift;
  assign o_wr_en     = r_vsr[LAT_POOL-1] ? r_mask : '0;
  assign o_wr_addr   = r_wr_ptr;
  assign o_buf_sel   = r_buf_sel;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cfg_err   = r_cfg_err;
  assign o_state     = r_state;

endmodule
